// File: rtl/rr_hold_arb.sv
// rtl/rr_hold_arb.sv - round-robin arbiter with per-grant hold limit and a dead cycle between grants
// Registered one-hot grant; search starts one past the last grantee.

module rr_hold_arb #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         GRANT,
  output logic [$clog2(N)-1:0] GRANT_ID,
  output logic                 BUSY,
  output logic                 TIMEOUT
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;

  // First set request at or after last+1, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_q) + k) % N);
      if (!found && REQ[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        if (found) begin
          grant_d    = N'(1) << pick;
          grant_id_d = pick;
          last_d     = pick;
          cnt_d      = CW'(1);
          state_d    = GRANTED;
        end else begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      GRANTED: begin
        if (!REQ[last_q]) begin
          grant_d = '0;
          state_d = RELEASE;
        end else if (cnt_q == CW'(MAX_HOLD)) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = |grant_d;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= IW'(N - 1);
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  assign GRANT    = grant_q;
  assign GRANT_ID = grant_id_q;
  assign BUSY     = busy_q;
  assign TIMEOUT  = timeout_q;

endmodule

// File: doc/rr_hold_arb.md
RR_HOLD_ARB -- requirements
Module: rr_hold_arb

Interface
REQ-001 SHALL have parameter N, default 8, meaning the number of requesters (2..16).
REQ-002 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of consecutive cycles one grant may stay high (1..255).
REQ-003 SHALL have port CLK  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port REQ  input  N  per-requester request level; requester i drives bit i and holds it high until it is done.
REQ-006 SHALL have port GRANT  output  N  registered grant; one-hot or all-zero.
REQ-007 SHALL have port GRANT_ID  output  clog2(N)  index of the current grantee; valid only while BUSY=1.
REQ-008 SHALL have port BUSY  output  1  high while any GRANT bit is high.
REQ-009 SHALL have port TIMEOUT  output  1  one-cycle pulse when a grant is revoked at the MAX_HOLD limit.

Function
REQ-010 SHALL implement three states:
- IDLE: no grant.
- GRANTED: one grant active.
- RELEASE: one mandatory dead cycle.
REQ-011 SHALL keep a last-grantee pointer LAST and a hold counter CNT of width clog2(MAX_HOLD+1).
REQ-012 SHALL, in IDLE or RELEASE at a rising edge with REQ != 0, select the first set REQ bit searching upward from (LAST+1) mod N with wrap-around, and act as follows:
- Set GRANT to that one-hot bit and GRANT_ID to its index.
- Set LAST to that index.
- Set CNT to 1.
- Enter GRANTED.
REQ-013 SHALL, in IDLE or RELEASE at a rising edge with REQ == 0, enter or stay in IDLE with GRANT = 0.
REQ-014 SHALL therefore present GRANT in the cycle after the edge at which REQ is first sampled high; request-to-grant latency is one edge when idle.
REQ-015 SHALL, in GRANTED at an edge where REQ[LAST]=0, clear GRANT and enter RELEASE; TIMEOUT stays 0.
REQ-016 SHALL, in GRANTED at an edge where REQ[LAST]=1 and CNT == MAX_HOLD, do the following:
- Clear GRANT.
- Pulse TIMEOUT high for exactly one cycle.
- Enter RELEASE.
REQ-017 SHALL, in GRANTED at an edge where REQ[LAST]=1 and CNT < MAX_HOLD, keep GRANT and increment CNT; CNT never wraps.
REQ-018 SHALL never assert GRANT for more than MAX_HOLD consecutive cycles, and SHALL never assert more than one GRANT bit.
REQ-019 SHALL ignore changes on non-granted REQ bits while in GRANTED; such changes do not pre-empt the grant.
REQ-020 SHALL keep GRANT = 0 for exactly one cycle (RELEASE) between any two grants, including a re-grant to the same requester.
REQ-021 SHALL, after a timeout, re-grant the same requester only if it is the only requester active at the RELEASE edge.
REQ-022 SHALL drive BUSY = |GRANT, and SHALL drive both BUSY and GRANT_ID from registers.

Reset
REQ-023 SHALL, while RESET=0, asynchronously force the following:
- state = IDLE, GRANT = 0, GRANT_ID = 0.
- BUSY = 0, TIMEOUT = 0, CNT = 0.
- LAST = N-1, so the first search starts at index 0.
REQ-024 SHALL, when RESET is asserted mid-grant, drop GRANT in the same cycle with no RELEASE cycle, and SHALL restart at the first rising edge after RESET deasserts.

Verification
REQ-025 SHALL cover round-robin order:
- Stimulus: after reset, REQ=8'hFF held; each grantee drops its REQ bit 2 cycles after GRANT.
- Required response: grant order 0,1,2,...,7,0; one zero cycle between grants.
REQ-026 SHALL cover timeout:
- Stimulus: MAX_HOLD=4; REQ=8'h04 held forever.
- Required response: GRANT=8'h04 for 4 cycles; TIMEOUT pulse; GRANT=0 for 1 cycle; GRANT=8'h04 again; this repeats.
REQ-027 SHALL cover timeout fairness:
- Stimulus: MAX_HOLD=4; REQ=8'h06 held.
- Required response: grants alternate 8'h02 and 8'h04, each 4 cycles, with a TIMEOUT pulse after each.
REQ-028 SHALL cover wrap-around:
- Stimulus: LAST=7; REQ=8'h81 at the same edge.
- Required response: GRANT=8'h01; next grant 8'h80.
REQ-029 SHALL cover no pre-emption:
- Stimulus: grant on 3; REQ[0] rises mid-grant.
- Required response: GRANT stays 8'h08 until REQ[3] falls; then one dead cycle; then GRANT=8'h01.
REQ-030 SHALL cover reset mid-grant:
- Stimulus: assert RESET low while GRANT=8'h20.
- Required response: GRANT, BUSY and TIMEOUT go to 0 immediately; after release with REQ=8'h21, first GRANT=8'h01.
